dmem_line_store: RTL

//  Line-granular backing data memory that sits directly downstream of the

---
 rtl/dmem_line_store.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dmem_line_store.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_store
// Brief    : Line-granular backing memory serving cache refill/write-back
//            requests with a fixed, parameterised ack latency.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_line_store #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_ACK  = 2'd2;
  localparam logic [1:0] c_GAP  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_write;
  logic [c_IDX_W-1:0] r_idx;
  logic [LINE_W-1:0]  r_wdata;
  logic [LINE_W-1:0]  r_rdata;
  logic [LINE_W-1:0]  r_mem [DEPTH];

  logic               w_accept;
  logic               w_cnt_dec;
  logic               w_cnt_zero;
  logic               w_read_load;
  logic               w_commit;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_unused_addr;

  // Offset bits and bits above the index are don't-care: addresses wrap.
  assign w_idx         = addr_i[5 +: c_IDX_W];
  assign w_unused_addr = ^{addr_i[31:5+c_IDX_W], addr_i[4:0]};
  assign w_cnt_zero    = (r_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (enable_i) w_state_next = c_BUSY;
      c_BUSY:  if (w_cnt_zero) w_state_next = c_ACK;
      c_ACK:   w_state_next = c_GAP;
      c_GAP:   w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_accept    = 1'b0;
    w_cnt_dec   = 1'b0;
    w_read_load = 1'b0;
    w_commit    = 1'b0;
    ack_o       = 1'b0;
    case (r_state)
      c_IDLE: w_accept = enable_i;
      c_BUSY: begin
        w_cnt_dec   = !w_cnt_zero;
        // Read data is captured on the way into ACK so it is stable all cycle.
        w_read_load = w_cnt_zero && !r_write;
      end
      c_ACK: begin
        ack_o    = 1'b1;
        w_commit = r_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= write_i;
        r_idx   <= w_idx;
        r_wdata <= data_i;
        r_cnt   <= c_CNT_LOAD;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_read_load) begin
        r_rdata <= r_mem[r_idx];
      end
    end
  end

  // No reset on the array; an async reset leaves ACK before this edge, so an
  // abandoned write never commits.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign data_o = r_rdata;

endmodule
`default_nettype wire
